// File: rtl/spu_branch_unit_pkg.sv
// Shared definitions for the SPU odd-pipe branch unit: opcodes, format codes,
// decoded-branch types and the opcode decoder.
package spu_branch_unit_pkg;

    localparam int unsigned PC_W     = 8;
    localparam int unsigned LINK_LAT = 3;

    // Instruction format codes
    localparam logic [2:0] FMT_RR   = 3'd0;
    localparam logic [2:0] FMT_RI16 = 3'd5;

    // RR-form branch opcodes (11 bits)
    localparam logic [10:0] OP_BI    = 11'b00110101000;
    localparam logic [10:0] OP_BISL  = 11'b00110101001;
    localparam logic [10:0] OP_BIZ   = 11'b00100101000;
    localparam logic [10:0] OP_BINZ  = 11'b00100101001;
    localparam logic [10:0] OP_BIHZ  = 11'b00100101010;
    localparam logic [10:0] OP_BIHNZ = 11'b00100101011;

    // RI16-form branch opcodes (9 bits, right-aligned in op)
    localparam logic [8:0] OP_BR    = 9'b001100100;
    localparam logic [8:0] OP_BRA   = 9'b001100000;
    localparam logic [8:0] OP_BRSL  = 9'b001100110;
    localparam logic [8:0] OP_BRASL = 9'b001100010;
    localparam logic [8:0] OP_BRZ   = 9'b001000000;
    localparam logic [8:0] OP_BRNZ  = 9'b001000010;
    localparam logic [8:0] OP_BRHZ  = 9'b001000100;
    localparam logic [8:0] OP_BRHNZ = 9'b001000110;

    // Where the branch target comes from
    typedef enum logic [1:0] {
        TGT_REL,    // pc_in + immediate
        TGT_ABS,    // immediate
        TGT_IND     // RA preferred word
    } tgt_sel_e;

    // Which condition decides the branch
    typedef enum logic [2:0] {
        CND_ALWAYS,
        CND_WZ,     // word == 0
        CND_WNZ,    // word != 0
        CND_HZ,     // halfword == 0
        CND_HNZ     // halfword != 0
    } cond_sel_e;

    typedef struct packed {
        logic      valid;   // recognised branch instruction
        tgt_sel_e  tgt;
        cond_sel_e cond;
        logic      link;    // writes pc+1 to rt
    } br_dec_t;

    // Opcode/format decode; anything unrecognised comes back with valid = 0.
    function automatic br_dec_t br_decode(input logic [10:0] op, input logic [2:0] fmt);
        br_dec_t d;
        d.valid = 1'b0;
        d.tgt   = TGT_REL;
        d.cond  = CND_ALWAYS;
        d.link  = 1'b0;
        case (fmt)
            FMT_RR: begin
                d.tgt = TGT_IND;
                case (op)
                    OP_BI:    d.valid = 1'b1;
                    OP_BISL:  begin d.valid = 1'b1; d.link = 1'b1; end
                    OP_BIZ:   begin d.valid = 1'b1; d.cond = CND_WZ;  end
                    OP_BINZ:  begin d.valid = 1'b1; d.cond = CND_WNZ; end
                    OP_BIHZ:  begin d.valid = 1'b1; d.cond = CND_HZ;  end
                    OP_BIHNZ: begin d.valid = 1'b1; d.cond = CND_HNZ; end
                    default:  d.valid = 1'b0;
                endcase
            end
            FMT_RI16: begin
                case (op[8:0])
                    OP_BR:    d.valid = 1'b1;
                    OP_BRA:   begin d.valid = 1'b1; d.tgt = TGT_ABS; end
                    OP_BRSL:  begin d.valid = 1'b1; d.link = 1'b1; end
                    OP_BRASL: begin d.valid = 1'b1; d.tgt = TGT_ABS; d.link = 1'b1; end
                    OP_BRZ:   begin d.valid = 1'b1; d.cond = CND_WZ;  end
                    OP_BRNZ:  begin d.valid = 1'b1; d.cond = CND_WNZ; end
                    OP_BRHZ:  begin d.valid = 1'b1; d.cond = CND_HZ;  end
                    OP_BRHNZ: begin d.valid = 1'b1; d.cond = CND_HNZ; end
                    default:  d.valid = 1'b0;
                endcase
            end
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/spu_branch_resolve.sv
// Combinational branch resolution: decodes the instruction, forms the target,
// evaluates the condition and produces the next PC and the link word.
module spu_branch_resolve
    import spu_branch_unit_pkg::*;
#(
    parameter int unsigned RES_PC_W = PC_W
) (
    input  logic [0:10]          op,
    input  logic [2:0]           format,
    input  logic [0:127]         ra,
    input  logic [0:127]         rt_st,
    input  logic [0:17]          imm,
    input  logic [RES_PC_W-1:0]  pc_in,
    output logic [RES_PC_W-1:0]  pc_next,
    output logic                 taken,
    output logic                 link,
    output logic [0:31]          link_word
);

    br_dec_t              dec;
    logic [RES_PC_W-1:0]  pc_inc;
    logic [RES_PC_W-1:0]  target;
    logic                 word_zero;
    logic                 half_zero;
    logic                 cond_ok;
    logic                 unused_bits;

    // Only the low bits of the immediate/RA word matter once the target is
    // reduced modulo the PC range, so sign extension is implicit.
    assign unused_bits = ^{ra, rt_st, imm};

    // Target selection, condition test and next-PC choice
    always_comb begin
        dec       = br_decode(op, format);
        pc_inc    = pc_in + RES_PC_W'(1);
        word_zero = ~|rt_st[0:31];
        half_zero = ~|rt_st[16:31];

        target = pc_inc;
        case (dec.tgt)
            TGT_REL: target = pc_in + imm[18-RES_PC_W:17];
            TGT_ABS: target = imm[18-RES_PC_W:17];
            TGT_IND: target = ra[32-RES_PC_W:31];
            default: target = pc_inc;
        endcase

        cond_ok = 1'b0;
        case (dec.cond)
            CND_ALWAYS: cond_ok = 1'b1;
            CND_WZ:     cond_ok = word_zero;
            CND_WNZ:    cond_ok = ~word_zero;
            CND_HZ:     cond_ok = half_zero;
            CND_HNZ:    cond_ok = ~half_zero;
            default:    cond_ok = 1'b0;
        endcase

        taken     = dec.valid & cond_ok;
        pc_next   = taken ? target : pc_inc;
        link      = dec.valid & dec.link;
        link_word = {{(32-RES_PC_W){1'b0}}, pc_inc};
    end

endmodule

// File: rtl/spu_branch_unit.sv
// SPU odd-pipe branch unit: registers the branch decision (1 cycle) and
// carries the link result to write-back through a LINK_LAT-stage pipeline.
module spu_branch_unit
    import spu_branch_unit_pkg::*;
#(
    parameter int unsigned PC_W     = spu_branch_unit_pkg::PC_W,
    parameter int unsigned LINK_LAT = spu_branch_unit_pkg::LINK_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:10]       op,
    input  logic [2:0]        format,
    input  logic [0:6]        rt_addr,
    input  logic [0:127]      ra,
    input  logic [0:127]      rb,
    input  logic [0:127]      rt_st,
    input  logic [0:17]       imm,
    input  logic              reg_write,
    input  logic [PC_W-1:0]   pc_in,
    output logic [0:127]      rt_wb,
    output logic [6:0]        rt_addr_wb,
    output logic              reg_write_wb,
    output logic [PC_W-1:0]   pc_wb,
    output logic              branch_taken
);

    logic [PC_W-1:0] pc_next;
    logic            taken;
    logic            link;
    logic [0:31]     link_word;
    logic            unused_rb;

    // Link pipeline stages; index 0 is stage 1. Only the preferred word is
    // carried because the remaining 96 bits of a link result are always zero.
    logic [0:31]     link_q [LINK_LAT];
    logic [6:0]      addr_q [LINK_LAT];
    logic            we_q   [LINK_LAT];

    assign unused_rb = ^rb;

    spu_branch_resolve #(
        .RES_PC_W (PC_W)
    ) u_resolve (
        .op        (op),
        .format    (format),
        .ra        (ra),
        .rt_st     (rt_st),
        .imm       (imm),
        .pc_in     (pc_in),
        .pc_next   (pc_next),
        .taken     (taken),
        .link      (link),
        .link_word (link_word)
    );

    // Branch result register: next PC and taken flag, updated every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_wb        <= '0;
            branch_taken <= 1'b0;
        end else begin
            pc_wb        <= pc_next;
            branch_taken <= taken;
        end
    end

    // Link pipeline: stage 1 captures the link result, later stages shift it on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LINK_LAT; i++) begin
                link_q[i] <= '0;
                addr_q[i] <= '0;
                we_q[i]   <= 1'b0;
            end
        end else begin
            link_q[0] <= link ? link_word : '0;
            addr_q[0] <= rt_addr;
            we_q[0]   <= link & reg_write;
            for (int unsigned i = 1; i < LINK_LAT; i++) begin
                link_q[i] <= link_q[i-1];
                addr_q[i] <= addr_q[i-1];
                we_q[i]   <= we_q[i-1];
            end
        end
    end

    assign rt_wb        = {link_q[LINK_LAT-1], 96'b0};
    assign rt_addr_wb   = addr_q[LINK_LAT-1];
    assign reg_write_wb = we_q[LINK_LAT-1];

endmodule

// File: tb/tb_spu_branch_unit.sv
// Directed self-checking bench for spu_branch_unit.
module tb_spu_branch_unit;

    logic          clk;
    logic          reset;
    logic [0:10]   op;
    logic [2:0]    format;
    logic [0:6]    rt_addr;
    logic [0:127]  ra;
    logic [0:127]  rb;
    logic [0:127]  rt_st;
    logic [0:17]   imm;
    logic          reg_write;
    logic [7:0]    pc_in;
    logic [0:127]  rt_wb;
    logic [6:0]    rt_addr_wb;
    logic          reg_write_wb;
    logic [7:0]    pc_wb;
    logic          branch_taken;

    int unsigned vectors;
    int unsigned miscompares;

    spu_branch_unit #(
        .PC_W     (8),
        .LINK_LAT (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .format       (format),
        .rt_addr      (rt_addr),
        .ra           (ra),
        .rb           (rb),
        .rt_st        (rt_st),
        .imm          (imm),
        .reg_write    (reg_write),
        .pc_in        (pc_in),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb),
        .pc_wb        (pc_wb),
        .branch_taken (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports miscompares
    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        op        = '0;
        format    = 3'd0;
        rt_addr   = '0;
        ra        = '0;
        rb        = '0;
        rt_st     = '0;
        imm       = '0;
        reg_write = 1'b0;
        pc_in     = 8'd0;
    endtask

    task automatic set_ri(input logic [8:0] opc, input logic [17:0] im, input logic [7:0] pc);
        op     = {2'b00, opc};
        format = 3'd5;
        imm    = im;
        pc_in  = pc;
    endtask

    task automatic set_rr(input logic [10:0] opc, input logic [7:0] pc);
        op     = opc;
        format = 3'd0;
        pc_in  = pc;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        set_nop();
        reset = 1'b1;
        repeat (3) step();

        // Reset state
        check_vec("rst_pc_wb",        128'(pc_wb),        128'd0);
        check_vec("rst_branch_taken", 128'(branch_taken), 128'd0);
        check_vec("rst_rt_wb",        rt_wb,              128'd0);
        check_vec("rst_rt_addr_wb",   128'(rt_addr_wb),   128'd0);
        check_vec("rst_reg_write_wb", 128'(reg_write_wb), 128'd0);
        reset = 1'b0;

        // bi: indirect target from RA preferred word
        set_rr(11'b00110101000, 8'h40);
        ra = {32'h00000025, 96'h0};
        step();
        check_vec("bi_pc",    128'(pc_wb),        128'h25);
        check_vec("bi_taken", 128'(branch_taken), 128'd1);
        set_nop();
        step();
        check_vec("bi_we_s2", 128'(reg_write_wb), 128'd0);
        step();
        check_vec("bi_we_s3", 128'(reg_write_wb), 128'd0);

        // brsl: relative branch with link, result after three cycles
        set_ri(9'b001100110, 18'd12, 8'd7);
        rt_addr   = 7'd3;
        reg_write = 1'b1;
        step();
        check_vec("brsl_pc",    128'(pc_wb),        128'd19);
        check_vec("brsl_taken", 128'(branch_taken), 128'd1);
        set_nop();
        step();
        check_vec("brsl_we_early", 128'(reg_write_wb), 128'd0);
        step();
        check_vec("brsl_rt_wb",   rt_wb,              {32'h00000008, 96'h0});
        check_vec("brsl_rt_addr", 128'(rt_addr_wb),   128'd3);
        check_vec("brsl_we",      128'(reg_write_wb), 128'd1);

        // br wrap at 256 and negative offset; bra absolute
        set_ri(9'b001100100, 18'd12, 8'd250);
        step();
        check_vec("br_wrap_pc", 128'(pc_wb), 128'd6);
        set_ri(9'b001100100, 18'h3FFFE, 8'd10);
        step();
        check_vec("br_neg_pc", 128'(pc_wb), 128'd8);
        set_ri(9'b001100000, 18'd12, 8'd100);
        step();
        check_vec("bra_pc",    128'(pc_wb),        128'd12);
        check_vec("bra_taken", 128'(branch_taken), 128'd1);

        // Word conditions with rt_st word0 = 1
        rt_st = {32'h00000001, 96'h0};
        set_ri(9'b001000010, 18'd12, 8'd20);
        step();
        check_vec("brnz_w1_pc",    128'(pc_wb),        128'd32);
        check_vec("brnz_w1_taken", 128'(branch_taken), 128'd1);
        set_ri(9'b001000000, 18'd12, 8'd20);
        step();
        check_vec("brz_w1_pc",    128'(pc_wb),        128'd21);
        check_vec("brz_w1_taken", 128'(branch_taken), 128'd0);

        // Word conditions with rt_st = 0 (nonzero bits outside word0 ignored)
        rt_st = {32'h0, 96'hFFFF};
        set_ri(9'b001000010, 18'd12, 8'd20);
        step();
        check_vec("brnz_w0_taken", 128'(branch_taken), 128'd0);
        check_vec("brnz_w0_pc",    128'(pc_wb),        128'd21);
        set_ri(9'b001000000, 18'd12, 8'd20);
        step();
        check_vec("brz_w0_taken", 128'(branch_taken), 128'd1);
        check_vec("brz_w0_pc",    128'(pc_wb),        128'd32);

        // Halfword conditions: upper half nonzero, tested half zero
        rt_st = {32'hABCD0000, 96'h0};
        set_ri(9'b001000100, 18'd12, 8'd20);
        step();
        check_vec("brhz_taken", 128'(branch_taken), 128'd1);
        check_vec("brhz_pc",    128'(pc_wb),        128'd32);
        set_ri(9'b001000110, 18'd12, 8'd20);
        step();
        check_vec("brhnz_taken", 128'(branch_taken), 128'd0);

        // Indirect conditional forms
        ra = {32'h00000025, 96'h0};
        set_rr(11'b00100101001, 8'd50);
        step();
        check_vec("binz_pc", 128'(pc_wb), 128'h25);
        set_rr(11'b00100101000, 8'd50);
        step();
        check_vec("biz_pc", 128'(pc_wb), 128'd51);
        set_rr(11'b00100101010, 8'd50);
        step();
        check_vec("bihz_pc", 128'(pc_wb), 128'h25);

        // Unknown format with a valid RI16 opcode is a non-branch
        set_ri(9'b001100100, 18'd12, 8'd70);
        format = 3'd3;
        step();
        check_vec("badfmt_pc",    128'(pc_wb),        128'd71);
        check_vec("badfmt_taken", 128'(branch_taken), 128'd0);

        // nop: pc+1, no link; non-link op with reg_write keeps rt_addr only
        set_nop();
        pc_in     = 8'd55;
        rt_addr   = 7'd9;
        reg_write = 1'b1;
        step();
        check_vec("nop_pc",    128'(pc_wb),        128'd56);
        check_vec("nop_taken", 128'(branch_taken), 128'd0);
        set_nop();
        repeat (2) step();
        check_vec("nop_we",      128'(reg_write_wb), 128'd0);
        check_vec("nop_rt_wb",   rt_wb,              128'd0);
        check_vec("nop_rt_addr", 128'(rt_addr_wb),   128'd9);

        // brasl from pc 255: absolute target, link value wraps to 0
        set_ri(9'b001100010, 18'h00040, 8'd255);
        rt_addr   = 7'h55;
        reg_write = 1'b1;
        step();
        check_vec("brasl_pc", 128'(pc_wb), 128'h40);
        set_nop();
        repeat (2) step();
        check_vec("brasl_rt_wb",   rt_wb,              128'd0);
        check_vec("brasl_rt_addr", 128'(rt_addr_wb),   128'h55);
        check_vec("brasl_we",      128'(reg_write_wb), 128'd1);

        // Reset with brsl in flight must discard the link write
        set_ri(9'b001100110, 18'd12, 8'd7);
        rt_addr   = 7'd3;
        reg_write = 1'b1;
        step();
        set_nop();
        #2 reset = 1'b1;
        #1;
        check_vec("flush_pc_wb", 128'(pc_wb), 128'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            check_vec("flush_we_rst", 128'(reg_write_wb), 128'd0);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_vec("flush_we_post", 128'(reg_write_wb), 128'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spu_branch_unit.md
Name:
spu_branch_unit

Overview:
Branch execution unit of the SPU odd pipe. It takes a decoded branch instruction from the RF/FWD stage and resolves the branch target and taken/not-taken decision. It also produces the link value for branch-and-set-link instructions and sends it to write-back. It sits between RF/FWD and WB, beside the other odd-pipe units.

Parameters:
PC_W, 8, program-counter width; PC is an instruction index, not a byte address.
LINK_LAT, 3, cycles from RF/FWD to rt_wb/rt_addr_wb/reg_write_wb.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
op  in  11 [0:10]  opcode, right-aligned; RR uses all 11 bits, RI16 uses op[2:10] with op[0:1]=0.
format  in  3  0=RR, 5=RI16; other values are treated as a non-branch.
rt_addr  in  7 [0:6]  destination register for the link value.
ra  in  128 [0:127]  RA value; target taken from the preferred word, ra[24:31].
rb  in  128 [0:127]  unused; kept for port uniformity.
rt_st  in  128 [0:127]  RT source value for conditional tests.
imm  in  18 [0:17]  immediate; RI16 uses imm[2:17], sign-extended.
reg_write  in  1  instruction requests a register write.
pc_in  in  8  PC of the current instruction.
rt_wb  out  128 [0:127]  link result.
rt_addr_wb  out  7  destination of rt_wb.
reg_write_wb  out  1  rt_wb is valid and is to be written.
pc_wb  out  8  next PC.
branch_taken  out  1  branch was taken.

Behaviour:
Supported opcodes:
- RR, format 0:
  - bi 00110101000
  - bisl 00110101001
  - biz 00100101000
  - binz 00100101001
  - bihz 00100101010
  - bihnz 00100101011
- RI16, format 5:
  - br 001100100
  - bra 001100000
  - brsl 001100110
  - brasl 001100010
  - brz 001000000
  - brnz 001000010
  - brhz 001000100
  - brhnz 001000110

Targets and arithmetic:
- Relative target = pc_in + imm[10:17], modulo 256 (two's complement; negative offsets work; wraps at 256).
- Absolute target (bra, brasl) = imm[10:17].
- Indirect target (bi*) = ra[24:31].
- Word test = rt_st[0:31]. Halfword test = rt_st[16:31].
  - z variants: taken when the tested field == 0.
  - nz variants: taken when the tested field != 0.
- Unconditional branches are always taken.

Branch outputs:
- Taken: pc_wb = target, branch_taken = 1.
- Not taken, or non-branch/unknown op/format: pc_wb = pc_in + 1 (mod 256), branch_taken = 0.
- pc_wb and branch_taken are registered with 1-cycle latency and update on every clock edge.

Link path (bisl, brsl, brasl):
- rt_wb[0:31] = zero-extended pc_in + 1; rt_wb[32:127] = 0.
- reg_write_wb = reg_write.
- rt_addr_wb = rt_addr.
- For all other ops: rt_wb = 0, reg_write_wb = 0, rt_addr_wb = rt_addr.
- The link path runs through LINK_LAT register stages (stage1→stage2→stage3); outputs come from stage 3.
- Pipeline is fully streaming: one instruction per cycle, no stalls, no handshake.

Reset (asynchronous, active-high):
- All pipeline registers and outputs go to 0: pc_wb = 0, branch_taken = 0, rt_wb = 0, rt_addr_wb = 0, reg_write_wb = 0.
- Reset asserted mid-operation discards all in-flight link results.
- The first valid outputs appear 1 cycle (branch) and 3 cycles (link) after reset deasserts.

Decomposition:
- Shared package: opcode localparams (RR 11-bit, RI16 9-bit), format codes (FMT_RR=0, FMT_RI16=5), PC_W.
- One sub-module, spu_branch_resolve: combinational target and condition evaluation.
- The top level holds the branch register and the 3-stage link pipeline.

Test Plan:
- Hold reset=1 → all outputs 0. Release; bi with ra word0=0x00000025 → next cycle pc_wb=0x25, branch_taken=1, reg_write_wb stays 0.
- brsl, pc_in=7, imm=12, rt_addr=3, reg_write=1 → pc_wb=19, taken=1; 3 cycles later rt_wb=0x00000008_0…0, rt_addr_wb=3, reg_write_wb=1.
- br pc_in=250, imm=12 → pc_wb=6 (wrap). br with imm=18'h3FFFE, pc_in=10 → pc_wb=8. bra imm=12 → pc_wb=12.
- rt_st word0=1:
  - brnz → taken, pc_wb=pc_in+12.
  - brz → not taken, pc_wb=pc_in+1.
- rt_st=0:
  - brnz → not taken.
  - brz → taken.
  - brhz with rt_st[16:31]=0 but rt_st[0:15]≠0 → taken.
- op=0 (nop) → branch_taken=0, pc_wb=pc_in+1, reg_write_wb=0. Assert reset with a brsl in flight → reg_write_wb never pulses.
